// File: rtl/axi_master128.sv
// Single-outstanding AXI3-style master with 128-bit data: a command port launches one
// INCR burst (read or write), streams the data beats and reports a one-cycle completion.
module axi_master128 #(
    parameter logic [3:0] AR_AW_CACHE = 4'b0011
) (
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst,

    // Command port
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [39:0]  cmd_addr,
    input  logic [7:0]   cmd_len,
    input  logic [7:0]   cmd_id,

    // Write-data source
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [127:0] wr_data,
    input  logic [15:0]  wr_strb,

    // Read-data sink
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [127:0] rd_data,
    output logic         rd_last,

    // Completion
    output logic         done_valid,
    output logic [1:0]   done_resp,

    // AR channel
    output logic [39:0]  araddr_m0,
    output logic [7:0]   arid_m0,
    output logic [7:0]   arlen_m0,
    output logic [2:0]   arsize_m0,
    output logic [1:0]   arburst_m0,
    output logic [3:0]   arcache_m0,
    output logic [2:0]   arprot_m0,
    output logic         arvalid_m0,
    input  logic         arready_m0,

    // AW channel
    output logic [39:0]  awaddr_m0,
    output logic [7:0]   awid_m0,
    output logic [7:0]   awlen_m0,
    output logic [2:0]   awsize_m0,
    output logic [1:0]   awburst_m0,
    output logic [3:0]   awcache_m0,
    output logic [2:0]   awprot_m0,
    output logic         awvalid_m0,
    input  logic         awready_m0,

    // W channel
    output logic [127:0] wdata_m0,
    output logic [15:0]  wstrb_m0,
    output logic [7:0]   wid_m0,
    output logic         wlast_m0,
    output logic         wvalid_m0,
    input  logic         wready_m0,

    // R channel
    input  logic [127:0] rdata_m0,
    input  logic [7:0]   rid_m0,
    input  logic [1:0]   rresp_m0,
    input  logic         rlast_m0,
    input  logic         rvalid_m0,
    output logic         rready_m0,

    // B channel
    input  logic [7:0]   bid_m0,
    input  logic [1:0]   bresp_m0,
    input  logic         bvalid_m0,
    output logic         bready_m0
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_RDATA = 3'd2,
        S_AW    = 3'd3,
        S_WDATA = 3'd4,
        S_BRESP = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [2:0] AXSIZE_16B = 3'b100;
    localparam logic [1:0] AXBURST_INCR = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state_q, state_d;
    logic [39:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  id_q, id_d;
    logic        write_q, write_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        cmd_fire;
    logic [8:0]  page_end;
    logic        page_cross;
    logic        last_beat;
    logic        r_beat;
    logic        w_beat;
    logic        r_beat_bad;
    logic        b_bad;

    // The last beat of the burst lands at 16-byte slot addr[11:4]+len; a carry out of
    // the 8-bit slot index means the burst would leave its 4KB page.
    assign page_end   = {1'b0, cmd_addr[11:4]} + {1'b0, cmd_len};
    assign page_cross = page_end[8];

    assign cmd_fire   = (state_q == S_IDLE) && cmd_valid;
    assign last_beat  = (cnt_q == len_q);
    assign r_beat     = (state_q == S_RDATA) && rvalid_m0 && rd_ready;
    assign w_beat     = (state_q == S_WDATA) && wr_valid && wready_m0;
    assign r_beat_bad = (rresp_m0 != 2'b00) || (rid_m0 != id_q) || (rlast_m0 != last_beat);
    assign b_bad      = (bresp_m0 != 2'b00) || (bid_m0 != id_q);

    // State and datapath registers
    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    addr_d  = cmd_addr & ~40'hF;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    write_d = cmd_write;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (page_cross) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (cmd_write) begin
                        state_d = S_AW;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (arready_m0) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (r_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (r_beat_bad) begin
                        err_d = 1'b1;
                    end
                    // Completion is decided by our own count, never by the slave's rlast.
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_AW: begin
                if (awready_m0) begin
                    state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                if (w_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) begin
                        state_d = S_BRESP;
                    end
                end
            end
            S_BRESP: begin
                if (bvalid_m0) begin
                    if (b_bad) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs, each owned by exactly one state
    always_comb begin
        cmd_ready  = 1'b0;
        arvalid_m0 = 1'b0;
        awvalid_m0 = 1'b0;
        rready_m0  = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        wvalid_m0  = 1'b0;
        wr_ready   = 1'b0;
        wlast_m0   = 1'b0;
        bready_m0  = 1'b0;
        done_valid = 1'b0;
        done_resp  = 2'b00;

        case (state_q)
            S_IDLE:  cmd_ready = 1'b1;
            S_AR:    arvalid_m0 = 1'b1;
            S_RDATA: begin
                rready_m0 = rd_ready;
                rd_valid  = rvalid_m0;
                rd_last   = last_beat;
            end
            S_AW:    awvalid_m0 = 1'b1;
            S_WDATA: begin
                wvalid_m0 = wr_valid;
                wr_ready  = wready_m0;
                wlast_m0  = last_beat;
            end
            S_BRESP: bready_m0 = 1'b1;
            S_DONE: begin
                done_valid = 1'b1;
                done_resp  = err_q ? RESP_SLVERR : 2'b00;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Address-channel fields come straight from the registered command, so they are
    // stable for the whole time valid is held.
    assign araddr_m0  = addr_q;
    assign arid_m0    = id_q;
    assign arlen_m0   = len_q;
    assign arsize_m0  = AXSIZE_16B;
    assign arburst_m0 = AXBURST_INCR;
    assign arcache_m0 = AR_AW_CACHE;
    assign arprot_m0  = 3'b000;

    assign awaddr_m0  = addr_q;
    assign awid_m0    = id_q;
    assign awlen_m0   = len_q;
    assign awsize_m0  = AXSIZE_16B;
    assign awburst_m0 = AXBURST_INCR;
    assign awcache_m0 = AR_AW_CACHE;
    assign awprot_m0  = 3'b000;

    assign wdata_m0 = wr_data;
    assign wstrb_m0 = wr_strb;
    assign wid_m0   = id_q;
    assign rd_data  = rdata_m0;

endmodule

// File: tb/tb_axi_master128.sv
// Directed bench for axi_master128: a table of burst commands with a scripted slave,
// plus hand sequences for stray responses and a mid-burst reset.
module tb_axi_master128;

    logic         clk;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [39:0]  cmd_addr;
    logic [7:0]   cmd_len, cmd_id;
    logic         wr_valid, wr_ready;
    logic [127:0] wr_data;
    logic [15:0]  wr_strb;
    logic         rd_valid, rd_ready, rd_last;
    logic [127:0] rd_data;
    logic         done_valid;
    logic [1:0]   done_resp;
    logic [39:0]  araddr, awaddr;
    logic [7:0]   arid, arlen, awid, awlen;
    logic [2:0]   arsize, arprot, awsize, awprot;
    logic [1:0]   arburst, awburst;
    logic [3:0]   arcache, awcache;
    logic         arvalid, arready, awvalid, awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic [7:0]   wid;
    logic         wlast, wvalid, wready;
    logic [127:0] rdata;
    logic [7:0]   rid, bid;
    logic [1:0]   rresp, bresp;
    logic         rlast, rvalid, rready;
    logic         bvalid, bready;

    int n_chk;
    int n_fail;

    axi_master128 dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp),
        .araddr_m0(araddr), .arid_m0(arid), .arlen_m0(arlen), .arsize_m0(arsize),
        .arburst_m0(arburst), .arcache_m0(arcache), .arprot_m0(arprot),
        .arvalid_m0(arvalid), .arready_m0(arready),
        .awaddr_m0(awaddr), .awid_m0(awid), .awlen_m0(awlen), .awsize_m0(awsize),
        .awburst_m0(awburst), .awcache_m0(awcache), .awprot_m0(awprot),
        .awvalid_m0(awvalid), .awready_m0(awready),
        .wdata_m0(wdata), .wstrb_m0(wstrb), .wid_m0(wid), .wlast_m0(wlast),
        .wvalid_m0(wvalid), .wready_m0(wready),
        .rdata_m0(rdata), .rid_m0(rid), .rresp_m0(rresp), .rlast_m0(rlast),
        .rvalid_m0(rvalid), .rready_m0(rready),
        .bid_m0(bid), .bresp_m0(bresp), .bvalid_m0(bvalid), .bready_m0(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          write;
        logic [39:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        int          stall;       // cycles of ready withheld (address phase and each W beat)
        int          rlast_beat;  // beat on which the slave raises rlast
        logic [1:0]  rresp;
        bit          bad_id;      // slave returns a wrong rid/bid
        logic [1:0]  bresp;
        bit          viol;        // 4KB crossing: no AXI traffic expected
        logic [39:0] exp_addr;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int v, input int b);
        logic [127:0] base;
        base = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        return base ^ {32'(v), 64'h0, 32'(b)};
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"},  wvalid, 0);
        chk({tag, "_rready"},  rready, 0);
        chk({tag, "_bready"},  bready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_done_valid"}, done_valid, 0);
        chk({tag, "_done_resp"}, done_resp, 0);
    endtask

    task automatic send_cmd(input vec_t v);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_id    = v.id;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_id    = '0;
    endtask

    task automatic finish_done(input vec_t v, input int idx);
        chk("done_valid", done_valid, 1);
        chk("done_resp", done_resp, v.exp_resp);
        chk("done_no_cmd_ready", cmd_ready, 0);
        $display("txn %0d: %s addr=%h len=%0d id=%h done_resp=%b (want %b)",
                 idx, v.write ? "WR" : "RD", v.addr, v.len, v.id, done_resp, v.exp_resp);
        step();
        chk("done_one_cycle", done_valid, 0);
        chk("back_to_idle", cmd_ready, 1);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        send_cmd(v);
        if (v.viol) begin
            chk("viol_no_arvalid", arvalid, 0);
            chk("viol_no_awvalid", awvalid, 0);
            finish_done(v, idx);
        end else if (!v.write) begin
            chk("ar_latency", arvalid, 1);
            chk("araddr", araddr, v.exp_addr);
            chk("arlen", arlen, v.len);
            chk("arid", arid, v.id);
            chk("arsize_burst_cache_prot", {arsize, arburst, arcache, arprot},
                {3'b100, 2'b01, 4'b0011, 3'b000});
            chk("ar_no_awvalid", awvalid, 0);
            for (int s = 0; s < v.stall; s++) begin
                step();
                chk("ar_hold", {arvalid, araddr}, {1'b1, v.exp_addr});
            end
            arready = 1'b1;
            step();
            arready = 1'b0;
            chk("ar_dropped", arvalid, 0);
            for (int b = 0; b <= int'(v.len); b++) begin
                rvalid   = 1'b1;
                rd_ready = 1'b1;
                rdata    = pat(idx, b);
                rid      = v.bad_id ? ~v.id : v.id;
                rresp    = v.rresp;
                rlast    = (b == v.rlast_beat);
                #1;
                chk("rd_valid", rd_valid, 1);
                chk("rready", rready, 1);
                chk("rd_data", rd_data, pat(idx, b));
                chk("rd_last", rd_last, (b == int'(v.len)));
                chk("rd_vs_cmd_ready", cmd_ready, 0);
                step();
            end
            rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0; rresp = '0; rid = '0;
            finish_done(v, idx);
        end else begin
            wr_valid = 1'b1;
            wr_data  = pat(idx, 0);
            #1;
            chk("aw_latency", awvalid, 1);
            chk("awaddr", awaddr, v.exp_addr);
            chk("awlen", awlen, v.len);
            chk("awid", awid, v.id);
            chk("aw_no_wvalid", wvalid, 0);
            chk("aw_no_wr_ready", wr_ready, 0);
            chk("aw_no_arvalid", arvalid, 0);
            for (int s = 0; s < v.stall; s++) begin
                step();
                chk("aw_hold", {awvalid, wvalid}, {1'b1, 1'b0});
            end
            awready = 1'b1;
            step();
            awready = 1'b0;
            chk("aw_dropped", awvalid, 0);
            for (int b = 0; b <= int'(v.len); b++) begin
                wr_valid = 1'b1;
                wr_data  = pat(idx, b);
                wr_strb  = 16'hFFFF ^ 16'(b);
                wready   = 1'b0;
                for (int s = 0; s < v.stall; s++) begin
                    #1;
                    chk("w_stall_valid", {wvalid, wr_ready}, {1'b1, 1'b0});
                    chk("w_stall_last", wlast, (b == int'(v.len)));
                    step();
                end
                wready = 1'b1;
                #1;
                chk("wr_ready", wr_ready, 1);
                chk("wdata", wdata, pat(idx, b));
                chk("wstrb", wstrb, 16'hFFFF ^ 16'(b));
                chk("wid", wid, v.id);
                chk("wlast", wlast, (b == int'(v.len)));
                step();
            end
            wready = 1'b0;
            chk("bresp_state_bready", bready, 1);
            chk("bresp_state_no_wvalid", wvalid, 0);
            wr_valid = 1'b0;
            bvalid = 1'b1;
            bresp  = v.bresp;
            bid    = v.bad_id ? ~v.id : v.id;
            step();
            bvalid = 1'b0; bresp = '0; bid = '0;
            finish_done(v, idx);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        //             wr    addr          len    id     stl rlb rresp bad bresp viol exp_addr      resp
        vecs[0] = '{1'b0, 40'h00_0000_1000, 8'd3,   8'h05, 0, 3,   2'b00, 1'b0, 2'b00, 1'b0, 40'h00_0000_1000, 2'b00};
        vecs[1] = '{1'b1, 40'h00_0000_2000, 8'd1,   8'h22, 3, 0,   2'b00, 1'b0, 2'b00, 1'b0, 40'h00_0000_2000, 2'b00};
        vecs[2] = '{1'b0, 40'h00_0000_0FF0, 8'd1,   8'h11, 0, 1,   2'b00, 1'b0, 2'b00, 1'b1, 40'h0,            2'b10};
        vecs[3] = '{1'b0, 40'h00_0000_3000, 8'd3,   8'h44, 1, 1,   2'b00, 1'b0, 2'b00, 1'b0, 40'h00_0000_3000, 2'b10};
        vecs[4] = '{1'b1, 40'h00_0000_4000, 8'd2,   8'h66, 0, 0,   2'b00, 1'b0, 2'b10, 1'b0, 40'h00_0000_4000, 2'b10};
        vecs[5] = '{1'b0, 40'h12_3456_5008, 8'd0,   8'h33, 0, 0,   2'b00, 1'b1, 2'b00, 1'b0, 40'h12_3456_5000, 2'b10};
        vecs[6] = '{1'b1, 40'h00_0000_0FFC, 8'd0,   8'h77, 1, 0,   2'b00, 1'b0, 2'b00, 1'b0, 40'h00_0000_0FF0, 2'b00};
        vecs[7] = '{1'b0, 40'h00_0000_7000, 8'd2,   8'h88, 0, 2,   2'b01, 1'b0, 2'b00, 1'b0, 40'h00_0000_7000, 2'b10};
        vecs[8] = '{1'b1, 40'h00_0000_0F00, 8'hFF,  8'h99, 0, 0,   2'b00, 1'b0, 2'b00, 1'b1, 40'h0,            2'b10};
        vecs[9] = '{1'b0, 40'h00_0000_8000, 8'd1,   8'hAA, 0, 255, 2'b00, 1'b0, 2'b00, 1'b0, 40'h00_0000_8000, 2'b10};

        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
        arready = 0; awready = 0; wready = 0;
        rdata = '0; rid = '0; rresp = '0; rlast = 0; rvalid = 0;
        bid = '0; bresp = '0; bvalid = 0;

        repeat (3) step();
        check_idle_outputs("reset");
        chk("reset_araddr", {araddr, arlen, arid}, 0);
        rst = 1'b0;
        step();
        chk("post_reset_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end

        // Stray R/B responses while idle must be ignored.
        rvalid = 1'b1; bvalid = 1'b1; rd_ready = 1'b1;
        #1;
        check_idle_outputs("stray");
        step();
        chk("stray_stay_idle", cmd_ready, 1);
        chk("stray_no_done", done_valid, 0);
        rvalid = 1'b0; bvalid = 1'b0; rd_ready = 1'b0;
        $display("txn stray: rvalid/bvalid in IDLE ignored");

        // Reset in the middle of a read burst: no completion, everything back to idle.
        send_cmd('{1'b0, 40'h6000, 8'd3, 8'h09, 0, 3, 2'b00, 1'b0, 2'b00, 1'b0, 40'h6000, 2'b00});
        chk("mid_ar", arvalid, 1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rd_ready = 1'b1; rid = 8'h09; rdata = pat(99, 0);
        #1;
        chk("mid_rd_valid", rd_valid, 1);
        step();
        rst = 1'b1;
        step();
        check_idle_outputs("midrst");
        chk("midrst_fields", {araddr, arlen, arid, awaddr, wid}, 0);
        rst = 1'b0;
        rvalid = 1'b0; rd_ready = 1'b0; rid = '0;
        step();
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_no_done", done_valid, 0);
        $display("txn reset: mid-burst reset returned to idle");

        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/axi_master128.md
AXI_MASTER128 -- requirements
Module: axi_master128

Interface
REQ-001 SHALL have parameter AR_AW_CACHE, default 4'b0011, driven on arcache_m0/awcache_m0.
REQ-002 SHALL have port pll_core_cpuclk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port pad_cpu_rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have cmd_valid/cmd_ready (in/out, 1 each), the command handshake.
REQ-005 SHALL have cmd_write, cmd_addr, cmd_len, cmd_id (in, 1/40/8/8): direction, byte address, beats-1, and AXI ID.
REQ-006 SHALL have wr_valid/wr_ready (in/out, 1 each), wr_data (in, 128) and wr_strb (in, 16), the write-data source.
REQ-007 SHALL have rd_valid (out, 1), rd_ready (in, 1), rd_data (out, 128) and rd_last (out, 1), the read-data sink.
REQ-008 SHALL have done_valid (out, 1) and done_resp (out, 2), the completion pulse and response.
REQ-009 SHALL have AR channel ports:
- outputs araddr_m0[39:0], arid_m0[7:0], arlen_m0[7:0], arsize_m0[2:0], arburst_m0[1:0], arcache_m0[3:0], arprot_m0[2:0], arvalid_m0;
- input arready_m0.
REQ-010 SHALL have AW channel ports: the same set named aw*_m0, with the same widths and directions.
REQ-011 SHALL have W channel ports: outputs wdata_m0[127:0], wstrb_m0[15:0], wid_m0[7:0], wlast_m0, wvalid_m0; input wready_m0.
REQ-012 SHALL have R channel ports: inputs rdata_m0[127:0], rid_m0[7:0], rresp_m0[1:0], rlast_m0, rvalid_m0; output rready_m0.
REQ-013 SHALL have B channel ports: inputs bid_m0[7:0], bresp_m0[1:0], bvalid_m0; output bready_m0.

Function
REQ-014 SHALL implement the FSM states IDLE, AR, RDATA, AW, WDATA, BRESP, DONE, with one transaction in flight at a time.
REQ-015 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready it SHALL register addr (with [3:0] forced to 0), len, id and write.
REQ-016 SHALL detect a 4KB crossing in IDLE: if addr[11:4]+len > 8'hFF, go to DONE with done_resp=2'b10 and issue no AXI traffic.
REQ-017 Otherwise IDLE SHALL go to AW if write, else to AR.
REQ-018 In AR, SHALL hold arvalid_m0=1 with stable fields until arready_m0, then go to RDATA.
- Fixed fields: arsize=3'b100, arburst=2'b01 (INCR), arprot=3'b000.
- arlen = registered len; arid = registered id.
REQ-019 In RDATA, SHALL drive rready_m0=rd_ready and rd_valid=rvalid_m0, with rd_data=rdata_m0 passed through combinationally.
REQ-020 In RDATA, SHALL drive rd_last=1 when the beat counter equals len.
REQ-021 The beat counter (8-bit) SHALL clear on entry to AR/AW and increment on each completed R or W beat.
REQ-022 SHALL latch an error flag in RDATA on any of:
- rresp_m0 != 0;
- rid_m0 != registered id;
- rlast_m0 asserted before the final beat;
- rlast_m0 absent on the final beat.
REQ-023 RDATA SHALL exit to DONE on the beat where counter==len and the beat completes, regardless of rlast_m0.
REQ-024 In AW, SHALL drive AW channel fields as in REQ-018 until awready_m0, then go to WDATA.
REQ-025 In WDATA, SHALL drive W channel signals:
- wvalid_m0=wr_valid, wr_ready=wready_m0;
- wdata_m0=wr_data, wstrb_m0=wr_strb, wid_m0=registered id;
- wlast_m0=(counter==len).
REQ-026 WDATA SHALL go to BRESP after the last beat completes.
REQ-027 No W beat SHALL be issued before the AW handshake.
REQ-028 In BRESP, SHALL drive bready_m0=1 and accept bvalid_m0.
- Error if bresp_m0 != 0 or bid_m0 != id.
- Then go to DONE.
REQ-029 DONE SHALL last exactly one cycle with done_valid=1, then return to IDLE.
- done_resp=2'b10 if the error flag or a 4KB violation occurred, else 2'b00.
REQ-030 SHALL deassert all valid/ready outputs outside their owning state; cmd_ready and rd_valid SHALL never be 1 together.
REQ-031 SHALL ignore cmd_valid outside IDLE, and ignore stray rvalid_m0 or bvalid_m0 outside RDATA and BRESP.
REQ-032 Minimum latency: command accept to arvalid_m0/awvalid_m0 SHALL be 1 cycle; last data beat or B handshake to done_valid SHALL be 1 cycle.

Reset
REQ-033 When pad_cpu_rst=1 at a clock edge, SHALL force the following, including mid-burst, with no completion pulse:
- state IDLE, counter 0, error flag 0;
- arvalid_m0, awvalid_m0, wvalid_m0, rready_m0, bready_m0, rd_valid, wr_ready, done_valid all 0;
- done_resp=0, registered fields 0;
- cmd_ready=1 on the first cycle after reset release.

Verification
REQ-034 Read, addr 40'h1000, len 3, slave OKAY -> one AR with araddr=40'h1000, arlen=3; four rd beats; rd_last on beat 3; done_resp=00.
REQ-035 Write, len 1, wready stalled 3 cycles per beat -> wlast_m0 only on the 2nd beat; AW precedes W; BRESP OKAY; done_resp=00.
REQ-036 Read, addr 40'h0FF0, len 1 -> no arvalid_m0; done_valid after 1 cycle; done_resp=10.
REQ-037 Read, len 3, slave asserts rlast_m0 on beat 1 -> all four beats delivered; done_resp=10.
REQ-038 Write, bresp_m0=2'b10, then pad_cpu_rst pulse during a later read's RDATA -> done_resp=10 for the write; after reset all outputs match REQ-033 and cmd_ready=1.
